// File: rtl/zz_pingpong_ctrl.sv
//------------------------------------------------------------------------------
// zz_pingpong_ctrl
//
// Ping-pong controller that shares two single-port 64x10 SRAM banks between a
// raster-order writer and a zigzag-order reader. While one bank is being
// filled with frame N, the other bank is drained in zigzag order (frame N-1).
// Blocks stream continuously, with no bubble between frames.
//
// Optional feature (macro SCAN_MODE_SEL_EN):
//   When defined, adds input scan_mode. It is sampled on the first read of a
//   frame and held for that frame. 0 selects zigzag order, 1 selects raster
//   order.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   scan_mode          (SCAN_MODE_SEL_EN only) read order select per frame
//   vld_in, din        raster-order input sample and its valid
//   rdy_in             controller can take a sample this cycle
//   rdy_out            sink accepts a sample next cycle (1-cycle lookahead)
//   vld_out, dout      zigzag-order output sample and its valid
//   sof_out, eof_out   first / last sample of a frame, qualified by vld_out
//   ovf                sticky: a sample was offered while rdy_in was low
//   mem_cs_n/w_en/r_en per-bank chip select (active low) and enables
//   mem_addr0/1        per-bank address
//   mem_din            shared write data
//   mem_dout0/1        per-bank registered read data (1-cycle latency)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module zz_pingpong_ctrl #(
  parameter int DATA_WIDTH   = 10,
  parameter int MAT_DIM_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef SCAN_MODE_SEL_EN
  input  logic                      scan_mode,
`endif
  input  logic                      vld_in,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic                      rdy_in,
  input  logic                      rdy_out,
  output logic                      vld_out,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      sof_out,
  output logic                      eof_out,
  output logic                      ovf,
  output logic [1:0]                mem_cs_n,
  output logic [1:0]                mem_w_en,
  output logic [1:0]                mem_r_en,
  output logic [2*MAT_DIM_LOG2-1:0] mem_addr0,
  output logic [2*MAT_DIM_LOG2-1:0] mem_addr1,
  output logic [DATA_WIDTH-1:0]     mem_din,
  input  logic [DATA_WIDTH-1:0]     mem_dout0,
  input  logic [DATA_WIDTH-1:0]     mem_dout1
);

  localparam int AW = 2 * MAT_DIM_LOG2;
  localparam int CW = MAT_DIM_LOG2;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [CW-1:0] MAX_COORD = {CW{1'b1}};

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  bank_state_e       bank0_q, bank0_d;
  bank_state_e       bank1_q, bank1_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              ovf_q, ovf_d;
  logic              vld_out_q, vld_out_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              rd_sel_q, rd_sel_d;
`ifdef SCAN_MODE_SEL_EN
  logic              scan_q, scan_d;
  logic              scan_eff;
`endif

  bank_state_e       wr_state;
  bank_state_e       rd_state;
  logic              wr_go;
  logic              rd_go;
  logic              wr_last;
  logic              rd_last;
  logic [1:0]        wr_en_v;
  logic [1:0]        rd_en_v;
  logic [AW-1:0]     rd_addr;

  // A bank is written only while EMPTY/FILLING and read only while
  // FULL/DRAINING, so a single bank never sees a write and a read together.
  function automatic bank_state_e next_bank(input bank_state_e cur,
                                            input logic        wr,
                                            input logic        rd,
                                            input logic        wl,
                                            input logic        rl);
    bank_state_e nxt;
    nxt = cur;
    if (wr) nxt = wl ? BANK_FULL : BANK_FILLING;
    if (rd) nxt = rl ? BANK_EMPTY : BANK_DRAINING;
    return nxt;
  endfunction

  // Handshake decode and memory port drive. Everything the SRAMs see is
  // decided combinationally from this cycle's handshake.
  always_comb begin
    wr_state = wr_bank_q ? bank1_q : bank0_q;
    rd_state = rd_bank_q ? bank1_q : bank0_q;
    rdy_in   = (wr_state == BANK_EMPTY) || (wr_state == BANK_FILLING);
    wr_go    = vld_in & rdy_in;
    rd_go    = rdy_out & ((rd_state == BANK_FULL) || (rd_state == BANK_DRAINING));
    wr_last  = (wr_cnt_q == LAST_ADDR);
    rd_last  = (rd_cnt_q == LAST_ADDR);
    wr_en_v  = {wr_go & wr_bank_q, wr_go & ~wr_bank_q};
    rd_en_v  = {rd_go & rd_bank_q, rd_go & ~rd_bank_q};

`ifdef SCAN_MODE_SEL_EN
    // The first read of a frame uses the live pin; later reads use the
    // value captured on that first read.
    scan_eff = (rd_cnt_q == '0) ? scan_mode : scan_q;
    rd_addr  = scan_eff ? rd_cnt_q : {row_q, col_q};
`else
    rd_addr  = {row_q, col_q};
`endif

    mem_w_en  = wr_en_v;
    mem_r_en  = rd_en_v;
    mem_cs_n  = ~(wr_en_v | rd_en_v);
    mem_din   = din;
    mem_addr0 = wr_en_v[0] ? wr_cnt_q : (rd_en_v[0] ? rd_addr : '0);
    mem_addr1 = wr_en_v[1] ? wr_cnt_q : (rd_en_v[1] ? rd_addr : '0);
  end

  // Next-state logic: bank states, write/read pointers, zigzag walker and
  // the registered output flags.
  always_comb begin
    bank0_d   = next_bank(bank0_q, wr_en_v[0], rd_en_v[0], wr_last, rd_last);
    bank1_d   = next_bank(bank1_q, wr_en_v[1], rd_en_v[1], wr_last, rd_last);
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    ovf_d     = ovf_q | (vld_in & ~rdy_in);
    vld_out_d = rd_go;
    sof_d     = rd_go & (rd_cnt_q == '0);
    eof_d     = rd_go & rd_last;
    rd_sel_d  = rd_go ? rd_bank_q : rd_sel_q;
`ifdef SCAN_MODE_SEL_EN
    scan_d    = (rd_go && (rd_cnt_q == '0)) ? scan_mode : scan_q;
`endif

    if (wr_go) begin
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d  = wr_cnt_q + 1'b1;
      end
    end

    if (rd_go) begin
      if (rd_last) begin
        rd_cnt_d  = '0;
        row_d     = '0;
        col_d     = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_cnt_d  = rd_cnt_q + 1'b1;
        // Even anti-diagonals run up-right, odd ones down-left; the edge
        // cases turn the walk onto the next diagonal.
        if ((row_q[0] ^ col_q[0]) == 1'b0) begin
          if (col_q == MAX_COORD) begin
            row_d = row_q + 1'b1;
          end else if (row_q == '0) begin
            col_d = col_q + 1'b1;
          end else begin
            row_d = row_q - 1'b1;
            col_d = col_q + 1'b1;
          end
        end else begin
          if (row_q == MAX_COORD) begin
            col_d = col_q + 1'b1;
          end else if (col_q == '0) begin
            row_d = row_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
            col_d = col_q - 1'b1;
          end
        end
      end
    end
  end

  // State registers. Reset drops any partially written or unread frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0_q   <= BANK_EMPTY;
      bank1_q   <= BANK_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ovf_q     <= 1'b0;
      vld_out_q <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      rd_sel_q  <= 1'b0;
`ifdef SCAN_MODE_SEL_EN
      scan_q    <= 1'b0;
`endif
    end else begin
      bank0_q   <= bank0_d;
      bank1_q   <= bank1_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ovf_q     <= ovf_d;
      vld_out_q <= vld_out_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      rd_sel_q  <= rd_sel_d;
`ifdef SCAN_MODE_SEL_EN
      scan_q    <= scan_d;
`endif
    end
  end

  // Output data comes from whichever bank was read last cycle. It is forced
  // to zero when not valid so that idle and reset outputs are all quiet.
  always_comb begin
    vld_out = vld_out_q;
    sof_out = sof_q;
    eof_out = eof_q;
    ovf     = ovf_q;
    dout    = '0;
    if (vld_out_q) dout = rd_sel_q ? mem_dout1 : mem_dout0;
  end

endmodule
